// File: rtl/ins_mem_ctrl.sv
// Instruction fetch responder with a direct-mapped, one-word-per-line cache.
// Misses read four bytes serially through the RAM arbiter.
module ins_mem_ctrl #(
    parameter int ICACHE_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        nd_ins,
    input  logic [31:0] pc_fetch,
    input  logic        jal_reset,
    output logic        flg_get,
    output logic [31:0] ins_in,
    output logic        mem_rd,
    output logic [31:0] mem_a,
    input  logic        bus_gnt,
    input  logic [7:0]  mem_din
);
    localparam int IDX   = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [2:0]              issue_q, issue_d;
    logic [1:0]              recv_q, recv_d;
    logic                    pend_q, pend_d;
    logic [23:0]             buf_q, buf_d;
    logic [31:0]             ins_q, ins_d;
    logic [ICACHE_LINES-1:0] valid_q;
    logic [TAG_W-1:0]        tag_q  [ICACHE_LINES];
    logic [31:0]             data_q [ICACHE_LINES];

    logic                    fill_en;
    logic [IDX-1:0]          fill_idx;
    logic [IDX-1:0]          lk_idx;
    logic                    lk_hit;

    assign lk_idx   = pc_fetch[IDX+1:2];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == pc_fetch[31:IDX+2]);
    assign fill_idx = addr_q[IDX+1:2];
    assign mem_a    = addr_q + {29'd0, issue_q};
    assign ins_in   = ins_q;
    // Read requests stay up during an abort cycle; a byte granted then is dropped.
    assign mem_rd   = rdy && (state_q == S_FETCH) && !issue_q[2];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        issue_d = issue_q;
        recv_d  = recv_q;
        pend_d  = pend_q;
        buf_d   = buf_q;
        ins_d   = ins_q;
        fill_en = 1'b0;
        flg_get = 1'b0;
        if (rdy) begin
            if (jal_reset) begin
                state_d = S_IDLE;
                issue_d = 3'd0;
                recv_d  = 2'd0;
                pend_d  = 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (nd_ins) begin
                            if (lk_hit) begin
                                ins_d   = data_q[lk_idx];
                                state_d = S_RESP;
                            end else begin
                                addr_d  = pc_fetch;
                                issue_d = 3'd0;
                                recv_d  = 2'd0;
                                pend_d  = 1'b0;
                                state_d = S_FETCH;
                            end
                        end
                    end
                    S_FETCH: begin
                        pend_d = bus_gnt && mem_rd;
                        if (bus_gnt && mem_rd) begin
                            issue_d = issue_q + 3'd1;
                        end
                        // Byte for last cycle's grant is on mem_din now.
                        if (pend_q) begin
                            recv_d = recv_q + 2'd1;
                            case (recv_q)
                                2'd0: buf_d[7:0]   = mem_din;
                                2'd1: buf_d[15:8]  = mem_din;
                                2'd2: buf_d[23:16] = mem_din;
                                default: begin
                                    ins_d   = {mem_din, buf_q};
                                    fill_en = 1'b1;
                                    state_d = S_RESP;
                                end
                            endcase
                        end
                    end
                    S_RESP: begin
                        flg_get = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            issue_q <= 3'd0;
            recv_q  <= 2'd0;
            pend_q  <= 1'b0;
            ins_q   <= 32'd0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
            pend_q  <= pend_d;
            ins_q   <= ins_d;
            if (fill_en) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Line contents and the assembly buffer carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
        if (fill_en) begin
            tag_q[fill_idx]  <= addr_q[31:IDX+2];
            data_q[fill_idx] <= ins_d;
        end
    end

endmodule

// File: doc/ins_mem_ctrl.md
# ins_mem_ctrl

Instruction-side memory responder: services the fetch stage's `nd_ins`/`pc_fetch` request, returns a 32-bit instruction with a one-cycle `flg_get` pulse, and hides the byte-wide RAM behind a direct-mapped instruction cache. It sits between the fetch stage and the RAM bus arbiter, which it shares with the load/store unit. Misses read four bytes serially through the arbiter, assemble the word little-endian, fill the cache and return the word. Fetch-stage redirects (`jal_reset`) abort any fetch in progress.

## Interface
- `ICACHE_LINES`, 16: number of one-word cache lines; power of 2, ≥2; `IDX = log2(ICACHE_LINES)`.
- `clk` input 1: system clock; single clock domain.
- `rst` input 1: reset, asynchronous, active-high.
- `rdy` input 1: global ready; low freezes all state.
- `nd_ins` input 1: fetch request from fetch stage; held high until served.
- `pc_fetch` input 32: fetch address; word-aligned.
- `jal_reset` input 1: fetch-stage redirect; aborts outstanding fetch.
- `flg_get` output 1: one-cycle pulse; `ins_in` valid this cycle.
- `ins_in` output 32: returned instruction word.
- `mem_rd` output 1: byte read request to arbiter.
- `mem_a` output 32: byte address of request; valid when `mem_rd`=1.
- `bus_gnt` input 1: arbiter grants the current `mem_rd` this cycle.
- `mem_din` input 8: RAM read data; byte for a granted request appears one cycle later.

## Operation
- Cache: `valid[ICACHE_LINES]`, `tag[ICACHE_LINES]` (32-IDX-2 bits), `data[ICACHE_LINES]` (32 bits). Index = `pc[IDX+1:2]`, tag = `pc[31:IDX+2]`. Reset clears all valid bits; tag/data are not reset.
- States: IDLE, FETCH, RESP.
- IDLE: when `nd_ins`=1 and `jal_reset`=0, look up `pc_fetch`. Hit: next state RESP with `ins_in` loaded from the line. Miss: latch `pc_fetch` into `addr`, clear `issue_cnt`, `recv_cnt`, `pending`; go FETCH.
- FETCH: `mem_rd`=1 while `issue_cnt`<4; `mem_a` = `addr + issue_cnt` (combinational). On `bus_gnt`=1: `issue_cnt`++, `pending`<=1; otherwise `pending`<=0. When `pending`=1, capture `mem_din` into byte `recv_cnt` of the word buffer (byte 0 → bits 7:0, ... byte 3 → bits 31:24), `recv_cnt`++. When the 4th byte is captured: write `valid`/`tag`/`data` at the index, load `ins_in`, go RESP.
- RESP: `flg_get`=1 for exactly this cycle; return to IDLE. A request seen in IDLE the following cycle (fetch stage stalled and re-requests) is served normally; a re-request of the same pc hits.
- `jal_reset`=1 in any state: next state IDLE, counters and `pending` cleared, no cache write, no `flg_get`; a byte arriving after abort is ignored. `jal_reset` in RESP suppresses the pulse.
- `nd_ins` deasserting mid-FETCH without `jal_reset` does not abort; the fetch completes and the cache is filled.
- `rdy`=0: every register holds; `mem_rd` forced 0. A byte pending at freeze is captured on the first `rdy`=1 cycle (SoC holds RAM output stable).
- `mem_a` addition wraps modulo 2^32.

## Timing
- Reset values: `flg_get`=0, `ins_in`=0, `mem_rd`=0, `mem_a`=0 (don't-care when `mem_rd`=0), state IDLE, all valid bits 0.
- Hit latency: request sampled at edge ending cycle T; `flg_get`=1 in T+1.
- Miss latency with continuous grant: issue bytes in T+1..T+4, data in T+2..T+5, `flg_get` in T+6. Each cycle of withheld grant adds one cycle.
- Cache fill becomes visible to a lookup in the cycle after RESP.
- `flg_get` never asserts on two consecutive cycles.

## Test plan
- Reset then request pc=0x0, RAM bytes 0x13,0x05,0x00,0x00, full grant -> `mem_a` 0,1,2,3 in cycles 1-4; `flg_get`=1 with `ins_in`=0x00000513 in cycle 6.
- Same pc=0x0 re-requested after RESP -> `flg_get` one cycle later, `mem_rd` stays 0.
- Miss at pc=0x100 with `bus_gnt` low for 3 cycles after byte 1 -> `flg_get` in cycle 9, word correctly assembled, no byte skipped or duplicated.
- `jal_reset` pulsed after 2 bytes of miss at 0x200, then request 0x40 -> no `flg_get` for 0x200, line 0x200 stays invalid, 0x40 served with correct data.
- Conflict: fill 0x0 then 0x40 (ICACHE_LINES=16, same index) -> re-request 0x0 misses and re-reads RAM.
- `rdy` low for 2 cycles mid-miss; async `rst` asserted mid-FETCH -> freeze adds exactly 2 cycles; reset immediately clears `flg_get`/`mem_rd`, all later lookups miss.
